// File: rtl/gpio_pkg.sv
// gpio_pkg: register map and handshake state encoding shared by the GPIO responder
package gpio_pkg;
  localparam logic [1:0] ADDR_SW = 2'd0;
  localparam logic [1:0] ADDR_LED = 2'd1;
  localparam logic [1:0] ADDR_EDGE = 2'd2;
  typedef enum logic [1:0] {IDLE, RESP, WAIT_REL} state_t;
endpackage

// File: rtl/sw_debounce.sv
// sw_debounce: two-flop synchroniser plus stability counter for one switch
module sw_debounce #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic deb,
  output logic rise
);
  logic s1, s2, hit;
  logic [CNT_W-1:0] cnt;
  assign hit = (s2 != deb) && (cnt == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign rise = hit & s2;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      cnt <= '0;
      deb <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
      cnt <= (s2 == deb || hit) ? '0 : cnt + 1'b1;
      deb <= deb ^ hit;
    end
  end
endmodule

// File: rtl/mmio_gpio_responder.sv
// mmio_gpio_responder: data-bus GPIO responder with debounced switches, LED register and sticky rise flags
module mmio_gpio_responder
  import gpio_pkg::*;
#(
  parameter int NUM_SW = 8,
  parameter int NUM_LED = 8,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               reb,
  input  logic [3:0]         web,
  input  logic [1:0]         addrb,
  input  logic [31:0]        dinb,
  output logic [31:0]        doutb,
  output logic               dreadyb,
  input  logic [NUM_SW-1:0]  sw_in,
  output logic [NUM_LED-1:0] led_out
);
  state_t state, state_nx;
  logic [NUM_SW-1:0] deb, rise, edge_flags, clr;
  logic [31:0] rdata;
  logic req, acc, unused_bits;
  assign req = reb | (|web);
  assign acc = (state == IDLE) && req;
  assign clr = (acc && web[0] && addrb == ADDR_EDGE) ? dinb[NUM_SW-1:0] : '0;
  assign unused_bits = ^dinb;
  for (genvar i = 0; i < NUM_SW; i++) begin : g_db
    sw_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_db (
      .clk(clk),
      .rst(rst),
      .raw(sw_in[i]),
      .deb(deb[i]),
      .rise(rise[i])
    );
  end
  always_comb begin
    state_nx = state;
    rdata = '0;
    state_nx = state == IDLE ? (req ? RESP : IDLE) : state == RESP ? WAIT_REL : (req ? WAIT_REL : IDLE);
    rdata = addrb == ADDR_SW ? 32'(deb) : addrb == ADDR_LED ? 32'(led_out) :
            addrb == ADDR_EDGE ? 32'(edge_flags) : 32'h0;
    dreadyb = state == RESP;
  end
  // read data is captured before the write lands, so a combined access returns the old value
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      doutb <= '0;
      led_out <= '0;
      edge_flags <= '0;
    end else begin
      state <= state_nx;
      if (acc) doutb <= rdata;
      if (acc && web[0] && addrb == ADDR_LED) led_out <= dinb[NUM_LED-1:0];
      edge_flags <= (edge_flags & ~clr) | rise;
    end
  end
endmodule

// File: tb/tb_mmio_gpio_responder.sv
// tb_mmio_gpio_responder: vector table, directed corner sequences and randomized accesses against a window-based model
module tb_mmio_gpio_responder;
  logic clk, rst, reb, dreadyb;
  logic [3:0] web;
  logic [1:0] addrb;
  logic [31:0] dinb, doutb;
  logic [7:0] sw_in, led_out;
  int checks = 0, errors = 0;
  logic [7:0] m_deb, m_edge, m_led, nd, clr;
  logic [7:0] hist[17];
  logic all_diff;
  bit acc_pending;

  typedef struct {
    logic r;
    logic [3:0] w;
    logic [1:0] a;
    logic [31:0] d;
    logic [31:0] dout;
    logic [7:0] led;
  } vec_t;
  vec_t tbl[9];

  mmio_gpio_responder dut (
    .clk(clk), .rst(rst), .reb(reb), .web(web), .addrb(addrb), .dinb(dinb),
    .doutb(doutb), .dreadyb(dreadyb), .sw_in(sw_in), .led_out(led_out)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // A debounced bit flips once the last 16 synchronised samples (sw_in two edges old) all disagree with it.
  always @(posedge clk) begin
    if (rst) begin
      m_deb = 0; m_edge = 0; m_led = 0; acc_pending = 0;
      for (int k = 0; k < 17; k++) hist[k] = 0;
    end else begin
      nd = m_deb;
      for (int i = 0; i < 8; i++) begin
        all_diff = 1;
        for (int k = 1; k <= 16; k++) if (hist[k][i] == m_deb[i]) all_diff = 0;
        if (all_diff) nd[i] = ~m_deb[i];
      end
      clr = (acc_pending && web[0] && addrb == 2'd2) ? dinb[7:0] : 8'h0;
      if (acc_pending && web[0] && addrb == 2'd1) m_led = dinb[7:0];
      m_edge = (m_edge & ~clr) | (nd & ~m_deb);
      m_deb = nd;
      acc_pending = 0;
      for (int k = 16; k > 0; k--) hist[k] = hist[k-1];
      hist[0] = sw_in;
    end
  end

  function automatic logic [31:0] exp_read(input logic [1:0] a);
    return a == 2'd0 ? {24'h0, m_deb} : a == 2'd1 ? {24'h0, m_led} : a == 2'd2 ? {24'h0, m_edge} : 32'h0;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Request is accepted at the next edge; dreadyb must pulse in the following cycle only.
  task automatic access(input logic r, input logic [3:0] w, input logic [1:0] a, input logic [31:0] d,
                        input string nm, output logic [31:0] rd);
    reb = r; web = w; addrb = a; dinb = d; acc_pending = 1;
    @(negedge clk);
    chk({nm, "/idle"}, 32'(dreadyb), 32'd0);
    tick(1);
    @(negedge clk);
    chk({nm, "/ready"}, 32'(dreadyb), 32'd1);
    rd = doutb;
    tick(1);
    reb = 0; web = 0;
    @(negedge clk);
    chk({nm, "/single"}, 32'(dreadyb), 32'd0);
    tick(1);
  endtask

  initial begin
    logic [31:0] rd, e;
    logic r;
    logic [3:0] w;
    logic [1:0] a;
    logic [31:0] d;
    int cnt;
    tbl[0] = '{1'b0, 4'h1, 2'd1, 32'h0000_00A5, 32'h0, 8'hA5};
    tbl[1] = '{1'b1, 4'h0, 2'd1, 32'h0, 32'h0000_00A5, 8'hA5};
    tbl[2] = '{1'b0, 4'hE, 2'd1, 32'hFFFF_FFFF, 32'h0000_00A5, 8'hA5};
    tbl[3] = '{1'b1, 4'h0, 2'd0, 32'h0, 32'h0, 8'hA5};
    tbl[4] = '{1'b1, 4'h0, 2'd3, 32'h0, 32'h0, 8'hA5};
    tbl[5] = '{1'b1, 4'hF, 2'd3, 32'hFFFF_FFFF, 32'h0, 8'hA5};
    tbl[6] = '{1'b1, 4'h1, 2'd1, 32'h0000_003C, 32'h0000_00A5, 8'h3C};
    tbl[7] = '{1'b1, 4'h0, 2'd1, 32'h0, 32'h0000_003C, 8'h3C};
    tbl[8] = '{1'b1, 4'h0, 2'd2, 32'h0, 32'h0, 8'h3C};
    rst = 1; reb = 1; web = 0; addrb = 1; dinb = 0; sw_in = 0; acc_pending = 0;
    tick(1);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("rst_ready", 32'(dreadyb), 32'd0);
      chk("rst_dout", doutb, 32'h0);
      chk("rst_led", 32'(led_out), 32'h0);
      tick(1);
    end
    rst = 0; reb = 0;
    @(negedge clk);
    chk("rst_release_ready", 32'(dreadyb), 32'd0);
    tick(1);
    reb = 1; addrb = 0; rst = 1;
    tick(1);
    rst = 0; reb = 0;
    @(negedge clk);
    chk("abort_ready0", 32'(dreadyb), 32'd0);
    tick(1);
    @(negedge clk);
    chk("abort_ready1", 32'(dreadyb), 32'd0);
    tick(1);
    for (int i = 0; i < 9; i++) begin
      access(tbl[i].r, tbl[i].w, tbl[i].a, tbl[i].d, $sformatf("vec%0d", i), rd);
      chk($sformatf("vec%0d_dout", i), rd, tbl[i].dout);
      chk($sformatf("vec%0d_led", i), 32'(led_out), 32'(tbl[i].led));
    end
    sw_in[3] = 1;
    tick(5);
    sw_in[3] = 0;
    access(1, 0, 0, 0, "glitch_rd", rd);
    chk("glitch_sw", rd, 32'h0);
    tick(4);
    sw_in[3] = 1;
    tick(17);
    access(1, 0, 0, 0, "step_rd17", rd);
    chk("step_sw_before", rd, 32'h0);
    access(1, 0, 0, 0, "step_rd20", rd);
    chk("step_sw_after", rd, 32'h8);
    access(1, 0, 2, 0, "edge_rd", rd);
    chk("edge_set", rd, 32'h8);
    access(0, 4'h1, 2, 32'h08, "edge_clr", rd);
    chk("edge_clr_old", rd, 32'h8);
    access(1, 0, 2, 0, "edge_rd2", rd);
    chk("edge_cleared", rd, 32'h0);
    sw_in[3] = 0;
    tick(20);
    access(1, 0, 0, 0, "fall_rd", rd);
    chk("fall_sw", rd, 32'h0);
    sw_in[3] = 1;
    tick(17);
    access(0, 4'h1, 2, 32'h08, "clr_vs_set", rd);
    chk("clr_vs_set_old", rd, 32'h0);
    access(1, 0, 2, 0, "edge_rd3", rd);
    chk("set_wins", rd, 32'h8);
    reb = 1; addrb = 0; cnt = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      cnt += 32'(dreadyb);
      tick(1);
    end
    chk("held_pulses", 32'(cnt), 32'd1);
    reb = 0;
    tick(1);
    reb = 1;
    tick(1);
    @(negedge clk);
    chk("rearm_ready", 32'(dreadyb), 32'd1);
    tick(1);
    reb = 0;
    tick(2);
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 7) == 0) sw_in = 8'($urandom);
      r = 1'($urandom);
      w = 4'($urandom_range(0, 15));
      if (!r && w == 0) r = 1;
      a = 2'($urandom);
      d = $urandom;
      e = exp_read(a);
      access(r, w, a, d, "rand", rd);
      chk("rand_dout", rd, e);
      chk("rand_led", 32'(led_out), 32'(m_led));
      tick($urandom_range(0, 2));
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
